debounce_scan_controller: RTL and testbench

- Time-multiplexes one shared debounce counter across c_NUM_SWITCHES raw push-button inputs.
- A scan FSM walks the channels. It locks onto any channel whose raw level differs from its debounced state, and commits the new state after c_DEBOUNCE_LIMIT stable cycles.
- Debounced press events queue as per-channel pending bits. A round-robin arbiter drains them onto a single valid/ready event port that feeds the seven-segment counter logic.

---
 rtl/debounce_scan_controller_pkg.sv | 18 +
 rtl/debounce_scan_controller_if.sv | 25 ++
 rtl/debounce_scan_controller_arbiter.sv | 54 +++++
 rtl/debounce_scan_controller.sv | 129 ++++++++++++
 tb/tb_debounce_scan_controller.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_scan_controller_pkg.sv
`default_nettype none
// debounce_scan_controller_pkg -- shared types/constants for the scanned debouncer (rev 1.0).
package debounce_scan_controller_pkg;

   typedef enum logic [0:0] {
      SCAN  = 1'b0,
      COUNT = 1'b1
   } scan_state_t;

   localparam int c_DEFAULT_DEBOUNCE_LIMIT = 250000;
   localparam int c_DEFAULT_CLK_HZ         = 25_000_000;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_scan_controller_if.sv
`default_nettype none
// debounce_scan_controller_if -- valid/ready event port (rev 1.0).
// DEBOUNCE_RELEASE_EVENT_EN adds o_Event_Release.
interface debounce_scan_controller_if
   import debounce_scan_controller_pkg::*;
#(
   parameter int c_NUM_SWITCHES = 4
);
   localparam int c_ID_W = idx_width(c_NUM_SWITCHES);

   logic              o_Event_Valid;
   logic [c_ID_W-1:0] o_Event_Id;
   logic              i_Event_Ready;
`ifdef DEBOUNCE_RELEASE_EVENT_EN
   logic              o_Event_Release;

   modport master (output o_Event_Valid, o_Event_Id, o_Event_Release, input i_Event_Ready);
   modport slave  (input o_Event_Valid, o_Event_Id, o_Event_Release, output i_Event_Ready);
`else
   modport master (output o_Event_Valid, o_Event_Id, input i_Event_Ready);
   modport slave  (input o_Event_Valid, o_Event_Id, output i_Event_Ready);
`endif

endinterface
`default_nettype wire

// File: rtl/debounce_scan_controller_arbiter.sv
`default_nettype none
// rr_event_arbiter -- round-robin pick from a pending vector into a registered valid/ready slot (rev 1.0).
module rr_event_arbiter
   import debounce_scan_controller_pkg::*;
#(
   parameter  int c_NUM_SOURCES = 4,
   localparam int c_SEL_W       = idx_width(c_NUM_SOURCES)
) (
   input  wire logic                     clk,
   input  wire logic                     rst_n,
   input  wire logic [c_NUM_SOURCES-1:0] pending,
   input  wire logic                     ready,
   output logic                          valid,
   output logic [c_SEL_W-1:0]            grant,
   output logic                          load,
   output logic [c_SEL_W-1:0]            load_idx
);

   logic [c_SEL_W-1:0] rr_ptr;
   logic               found;

   // First set bit at or above rr_ptr, wrapping past the top source.
   always_comb begin
      found    = 1'b0;
      load_idx = '0;
      for (int k = 0; k < c_NUM_SOURCES; k++) begin
         int j;
         j = int'(rr_ptr) + k;
         if (j >= c_NUM_SOURCES) j = j - c_NUM_SOURCES;
         if (!found && pending[c_SEL_W'(j)]) begin
            found    = 1'b1;
            load_idx = c_SEL_W'(j);
         end
      end
   end

   assign load = found && (!valid || ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         grant  <= '0;
         rr_ptr <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         grant  <= load_idx;
         rr_ptr <= (load_idx == c_SEL_W'(c_NUM_SOURCES - 1)) ? '0 : load_idx + 1'b1;
      end else if (ready) begin
         valid  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/debounce_scan_controller.sv
`default_nettype none
// debounce_scan_controller -- one shared debounce counter scanned across all switches (rev 1.0).
// DEBOUNCE_RELEASE_EVENT_EN also queues release events and drives o_Event_Release.
module debounce_scan_controller
   import debounce_scan_controller_pkg::*;
#(
   parameter int c_NUM_SWITCHES   = 4,
   parameter int c_DEBOUNCE_LIMIT = c_DEFAULT_DEBOUNCE_LIMIT
) (
   input  wire logic                      i_Clk,
   input  wire logic                      i_Rst_L,
   input  wire logic [c_NUM_SWITCHES-1:0] i_Switch,
   output logic [c_NUM_SWITCHES-1:0]      o_Switch,
   output logic                           o_Overflow,
   debounce_scan_controller_if.master     evt
);

   localparam int c_CNT_W = $clog2(c_DEBOUNCE_LIMIT + 1);
   localparam int c_IDX_W = idx_width(c_NUM_SWITCHES);
`ifdef DEBOUNCE_RELEASE_EVENT_EN
   localparam int c_NUM_SRC = 2 * c_NUM_SWITCHES;
`else
   localparam int c_NUM_SRC = c_NUM_SWITCHES;
`endif
   localparam int c_SRC_W = idx_width(c_NUM_SRC);

   scan_state_t          state, state_nx;
   logic [c_CNT_W-1:0]   cnt, cnt_nx;
   logic [c_IDX_W-1:0]   idx, idx_nx, idx_inc;
   logic                 mismatch;
   logic                 commit;
   logic [c_NUM_SRC-1:0] pending, set_vec, clr_vec;
   logic                 arb_valid, arb_load;
   logic [c_SRC_W-1:0]   arb_grant, arb_load_idx;

   assign idx_inc  = (idx == c_IDX_W'(c_NUM_SWITCHES - 1)) ? '0 : idx + 1'b1;
   assign mismatch = i_Switch[idx] != o_Switch[idx];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      commit   = 1'b0;
      case (state)
         SCAN: begin
            if (mismatch) begin
               state_nx = COUNT;
               cnt_nx   = c_CNT_W'(1);
            end else begin
               idx_nx   = idx_inc;
            end
         end
         COUNT: begin
            if (!mismatch) begin
               state_nx = SCAN;
               cnt_nx   = '0;
               idx_nx   = idx_inc;
            end else if (cnt == c_CNT_W'(c_DEBOUNCE_LIMIT - 1)) begin
               state_nx = SCAN;
               cnt_nx   = '0;
               idx_nx   = idx_inc;
               commit   = 1'b1;
            end else begin
               cnt_nx   = cnt + 1'b1;
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   // Press sources sit at even slots, releases at odd slots, when release events are enabled.
   always_comb begin
      set_vec = '0;
      if (commit) begin
`ifdef DEBOUNCE_RELEASE_EVENT_EN
         set_vec[{idx, ~i_Switch[idx]}] = 1'b1;
`else
         set_vec[idx] = i_Switch[idx];
`endif
      end
   end

   always_comb begin
      clr_vec = '0;
      if (arb_load) clr_vec[arb_load_idx] = 1'b1;
   end

   // A set landing on the same edge as its load-clear survives, so it is not an overflow.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state      <= SCAN;
         cnt        <= '0;
         idx        <= '0;
         o_Switch   <= '0;
         pending    <= '0;
         o_Overflow <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         idx     <= idx_nx;
         pending <= (pending & ~clr_vec) | set_vec;
         if (commit) o_Switch[idx] <= i_Switch[idx];
         if (|(set_vec & pending & ~clr_vec)) o_Overflow <= 1'b1;
      end
   end

   rr_event_arbiter #(
      .c_NUM_SOURCES (c_NUM_SRC)
   ) u_arbiter (
      .clk      (i_Clk),
      .rst_n    (i_Rst_L),
      .pending  (pending),
      .ready    (evt.i_Event_Ready),
      .valid    (arb_valid),
      .grant    (arb_grant),
      .load     (arb_load),
      .load_idx (arb_load_idx)
   );

   assign evt.o_Event_Valid = arb_valid;
`ifdef DEBOUNCE_RELEASE_EVENT_EN
   assign evt.o_Event_Id      = arb_grant[c_SRC_W-1:1];
   assign evt.o_Event_Release = arb_grant[0];
`else
   assign evt.o_Event_Id      = arb_grant;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce_scan_controller.sv
`default_nettype none
// tb_debounce_scan_controller -- self-checking bench, 4 switches, debounce limit 4.
module tb_debounce_scan_controller;

   localparam int c_N     = 4;
   localparam int c_LIMIT = 4;

   typedef struct {
      int id;
      int rel;
   } ev_t;

   typedef struct {
      logic [3:0]  mask;
      int          n_ev;
      logic [15:0] order;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [c_N-1:0] sw;
   logic [c_N-1:0] sw_db;
   logic           ovf;
   ev_t            exp_q[$];
   vec_t           tbl[4];
   int             n_cmp = 0;
   int             n_bad = 0;

   debounce_scan_controller_if #(.c_NUM_SWITCHES(c_N)) ev_if();

   debounce_scan_controller #(
      .c_NUM_SWITCHES   (c_N),
      .c_DEBOUNCE_LIMIT (c_LIMIT)
   ) dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_n),
      .i_Switch   (sw),
      .o_Switch   (sw_db),
      .o_Overflow (ovf),
      .evt        (ev_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_ev(input int id, input int rel);
      ev_t e;
      e.id  = id;
      e.rel = rel;
      exp_q.push_back(e);
   endtask

   // Each step: score any handshake at the falling edge, then land 1 time unit after the rising edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rst_n && ev_if.o_Event_Valid && ev_if.i_Event_Ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", 1, 0);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               check("event_id", int'(ev_if.o_Event_Id), e.id);
`ifdef DEBOUNCE_RELEASE_EVENT_EN
               check("event_release", int'(ev_if.o_Event_Release), e.rel);
`endif
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sw    = '0;
      ev_if.i_Event_Ready = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_sw(input int ch, input logic lvl, input int budget);
      int k;
      k = 0;
      while (sw_db[ch] != lvl && k < budget) begin
         step(1);
         k++;
      end
      if (sw_db[ch] != lvl) check("wait_sw_timeout", int'(sw_db[ch]), int'(lvl));
   endtask

   initial begin
      rst_n = 1'b1;
      sw    = '0;
      ev_if.i_Event_Ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_switch",   int'(sw_db), 0);
      check("rst_valid",    int'(ev_if.o_Event_Valid), 0);
      check("rst_id",       int'(ev_if.o_Event_Id), 0);
      check("rst_overflow", int'(ovf), 0);

      // Clean press on channel 2: detected on the third edge, committed on the sixth.
      do_reset();
      sw[2] = 1'b1;
      step(5);
      check("press_pre_commit", int'(sw_db), 4'b0000);
      step(1);
      check("press_commit", int'(sw_db), 4'b0100);
      check("press_valid_lag", int'(ev_if.o_Event_Valid), 0);
      push_ev(2, 0);
      step(1);
      check("press_valid", int'(ev_if.o_Event_Valid), 1);
      check("press_id", int'(ev_if.o_Event_Id), 2);
      step(2);
      check("press_hold_valid", int'(ev_if.o_Event_Valid), 1);
      check("press_hold_id", int'(ev_if.o_Event_Id), 2);
      ev_if.i_Event_Ready = 1'b1;
      step(1);
      check("press_accepted", int'(ev_if.o_Event_Valid), 0);

      // Bounce on channel 1; the scan must resume at channel 2.
      do_reset();
      ev_if.i_Event_Ready = 1'b1;
      sw[1] = 1'b1;
      step(3);
      sw[1] = 1'b0;
      sw[2] = 1'b1;
      step(4);
      check("bounce_no_commit", int'(sw_db), 4'b0000);
      check("bounce_no_event", int'(ev_if.o_Event_Valid), 0);
      step(1);
      check("bounce_resume_ch2", int'(sw_db), 4'b0100);
      push_ev(2, 0);
      step(3);
      check("bounce_drained", int'(ev_if.o_Event_Valid), 0);

      // Stalled multi-press table: events drain in round-robin order, one per cycle.
      tbl[0].mask = 4'b1111; tbl[0].n_ev = 4; tbl[0].order = 16'h3210;
      tbl[1].mask = 4'b1010; tbl[1].n_ev = 2; tbl[1].order = 16'h0031;
      tbl[2].mask = 4'b0101; tbl[2].n_ev = 2; tbl[2].order = 16'h0020;
      tbl[3].mask = 4'b1001; tbl[3].n_ev = 2; tbl[3].order = 16'h0030;
      for (int t = 0; t < 4; t++) begin
         do_reset();
         sw = tbl[t].mask;
         for (int k = 0; k < tbl[t].n_ev; k++) push_ev(int'(tbl[t].order[4*k +: 4]), 0);
         step(30);
         check("tbl_switch", int'(sw_db), int'(tbl[t].mask));
         check("tbl_first_valid", int'(ev_if.o_Event_Valid), 1);
         check("tbl_first_id", int'(ev_if.o_Event_Id), int'(tbl[t].order[3:0]));
         ev_if.i_Event_Ready = 1'b1;
         step(tbl[t].n_ev);
         check("tbl_back_to_back", exp_q.size(), 0);
         check("tbl_idle", int'(ev_if.o_Event_Valid), 0);
      end

      // Round-robin wrap: after channel 2 is granted, pending 0 and 3 drain as 3 then 0.
      do_reset();
      sw[2] = 1'b1;
      step(6);
      push_ev(2, 0);
      sw[0] = 1'b1;
      sw[3] = 1'b1;
      push_ev(3, 0);
      push_ev(0, 0);
      step(12);
      check("wrap_switch", int'(sw_db), 4'b1101);
      check("wrap_no_overflow", int'(ovf), 0);
      ev_if.i_Event_Ready = 1'b1;
      step(3);
      check("wrap_drained", int'(ev_if.o_Event_Valid), 0);

      // Stall with repeated presses on channel 0: the third press overflows and is dropped.
      do_reset();
      sw[0] = 1'b1;
      push_ev(0, 0);
      wait_sw(0, 1'b1, 20);
      sw[0] = 1'b0;
`ifdef DEBOUNCE_RELEASE_EVENT_EN
      push_ev(0, 1);
`endif
      wait_sw(0, 1'b0, 20);
      sw[0] = 1'b1;
      push_ev(0, 0);
      wait_sw(0, 1'b1, 20);
      check("ovf_second_press", int'(ovf), 0);
      sw[0] = 1'b0;
      wait_sw(0, 1'b0, 20);
`ifdef DEBOUNCE_RELEASE_EVENT_EN
      check("ovf_second_release", int'(ovf), 1);
`else
      check("ovf_second_release", int'(ovf), 0);
`endif
      sw[0] = 1'b1;
      wait_sw(0, 1'b1, 20);
      step(1);
      check("ovf_third_press", int'(ovf), 1);
      check("ovf_held_valid", int'(ev_if.o_Event_Valid), 1);
      check("ovf_held_id", int'(ev_if.o_Event_Id), 0);
      ev_if.i_Event_Ready = 1'b1;
      step(4);
      check("ovf_drained", int'(ev_if.o_Event_Valid), 0);
      check("ovf_sticky", int'(ovf), 1);

      // Reset while channel 1 is mid-count, then a full re-debounce.
      do_reset();
      sw = 4'b0011;
      step(6);
      check("midrst_pre_switch", int'(sw_db), 4'b0001);
      check("midrst_pre_valid", int'(ev_if.o_Event_Valid), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_switch", int'(sw_db), 0);
      check("midrst_valid", int'(ev_if.o_Event_Valid), 0);
      check("midrst_id", int'(ev_if.o_Event_Id), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4);
      check("midrst_ch0", int'(sw_db), 4'b0001);
      push_ev(0, 0);
      step(3);
      check("midrst_ch1_pre", int'(sw_db), 4'b0001);
      step(1);
      check("midrst_ch1", int'(sw_db), 4'b0011);
      push_ev(1, 0);
      ev_if.i_Event_Ready = 1'b1;
      step(4);
      check("midrst_drained", int'(ev_if.o_Event_Valid), 0);

`ifdef DEBOUNCE_RELEASE_EVENT_EN
      // Press then release channel 3 yields a press event then a release event.
      do_reset();
      ev_if.i_Event_Ready = 1'b1;
      sw[3] = 1'b1;
      push_ev(3, 0);
      wait_sw(3, 1'b1, 30);
      sw[3] = 1'b0;
      push_ev(3, 1);
      wait_sw(3, 1'b0, 30);
      step(3);
      check("rel_drained", int'(ev_if.o_Event_Valid), 0);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
